des_core: RTL and testbench

Parametrised iterative DES engine, the successor to the single-mode DES decrypt block. One 64-bit block is processed per transaction, in either direction, selected per block by `mode`. `ROUNDS_PER_CYCLE` Feistel rounds are unrolled per clock, and subkeys are generated on the fly without a stored key table. The block sits between the image block buffer and the output formatter and uses the codebase's `enable`/`done`/`ack` handshake.

---
 rtl/des_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_des_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_core.sv
// rtl/des_core.sv - Iterative DES engine, ROUNDS_PER_CYCLE Feistel rounds per clock, on-the-fly key schedule.
// Optional CBC chaining is enabled by defining DES_CBC_EN; the default build is ECB only.
module des_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mode,
    input  logic [63:0] message,
    input  logic [63:0] DESkey,
`ifdef DES_CBC_EN
    input  logic [63:0] iv,
    input  logic        chain_restart,
`endif
    input  logic        ack,
    output logic [63:0] result,
    output logic        done,
    output logic        busy
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rounds
        $error("des_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST = 5'(16 - ROUNDS_PER_CYCLE);

    // Tables hold 1-based FIPS bit numbers, bit 1 being the MSB.
    localparam logic [6:0] IP_T [0:63] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam logic [6:0] FP_T [0:63] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam logic [6:0] E_T [0:47] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam logic [6:0] P_T [0:31] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam logic [6:0] PC1_T [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam logic [6:0] PC2_T [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
        26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // Each S-box is 64 nibbles in row-major order, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [0:7] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] r = '0;
        for (int p = 0; p < 64; p++) r[6'(63 - p)] = x[6'(64 - int'(IP_T[6'(p)]))];
        return r;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] r = '0;
        for (int p = 0; p < 64; p++) r[6'(63 - p)] = x[6'(64 - int'(FP_T[6'(p)]))];
        return r;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] r = '0;
        for (int p = 0; p < 56; p++) r[6'(55 - p)] = x[6'(64 - int'(PC1_T[6'(p)]))];
        return r;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] r = '0;
        for (int p = 0; p < 48; p++) r[6'(47 - p)] = x[6'(56 - int'(PC2_T[6'(p)]))];
        return r;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] rh, input logic [47:0] k);
        logic [47:0] x = '0;
        logic [31:0] s = '0;
        logic [31:0] r = '0;
        logic [5:0]  six;
        logic [5:0]  idx;
        logic [7:0]  base;
        for (int p = 0; p < 48; p++) x[6'(47 - p)] = rh[5'(32 - int'(E_T[6'(p)]))];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six  = x[6'(47 - 6 * b) -: 6];
            idx  = {six[5], six[0], six[4:1]};
            base = 8'd255 - {idx, 2'b00};
            s[5'(31 - 4 * b) -: 4] = SBOX[3'(b)][base -: 4];
        end
        for (int p = 0; p < 32; p++) r[5'(31 - p)] = s[5'(32 - int'(P_T[5'(p)]))];
        return r;
    endfunction

    function automatic logic single_shift(input logic [4:0] i);
        return (i == 5'd1) || (i == 5'd2) || (i == 5'd9) || (i == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic one);
        return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t      state, state_n;
    logic        mode_q;
    logic [4:0]  cnt_q;
    logic [31:0] l_q, r_q, l_n, r_n, tmp;
    logic [27:0] c_q, d_q, c_n, d_n;
    logic [4:0]  rnd;
    logic        one;
    logic [63:0] cipher_in;
    logic [63:0] fp_out;

`ifdef DES_CBC_EN
    logic [63:0] chain_q, msg_q, chain_sel;
    assign chain_sel = chain_restart ? iv : chain_q;
    assign cipher_in = mode ? message : (message ^ chain_sel);
`else
    assign cipher_in = message;
`endif

    assign fp_out = perm_fp({r_q, l_q});

    // Decrypt starts from the unrotated C0/D0 (K16) and walks the schedule backwards.
    always_comb begin
        l_n = l_q;
        r_n = r_q;
        c_n = c_q;
        d_n = d_q;
        rnd = '0;
        one = 1'b0;
        tmp = '0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            rnd = cnt_q + 5'(k) + 5'd1;
            if (!mode_q) begin
                one = single_shift(rnd);
                c_n = rotl(c_n, one);
                d_n = rotl(d_n, one);
            end else if (rnd != 5'd1) begin
                one = single_shift(5'd18 - rnd);
                c_n = rotr(c_n, one);
                d_n = rotr(d_n, one);
            end
            tmp = r_n;
            r_n = l_n ^ feistel(r_n, perm_pc2({c_n, d_n}));
            l_n = tmp;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable) state_n = ROUND;
            ROUND:   if (cnt_q == LAST) state_n = FINAL;
            FINAL:   state_n = DONE;
            DONE:    if (ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
`ifdef DES_CBC_EN
            chain_q <= '0;
            msg_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (enable) begin
                    mode_q       <= mode;
                    {l_q, r_q}   <= perm_ip(cipher_in);
                    {c_q, d_q}   <= perm_pc1(DESkey);
                    cnt_q        <= '0;
`ifdef DES_CBC_EN
                    chain_q      <= chain_sel;
                    msg_q        <= message;
`endif
                end
                ROUND: begin
                    l_q   <= l_n;
                    r_q   <= r_n;
                    c_q   <= c_n;
                    d_q   <= d_n;
                    cnt_q <= cnt_q + STEP;
                end
                FINAL: begin
`ifdef DES_CBC_EN
                    if (mode_q) begin
                        result  <= fp_out ^ chain_q;
                        chain_q <= msg_q;
                    end else begin
                        result  <= fp_out;
                        chain_q <= fp_out;
                    end
`else
                    result <= fp_out;
`endif
                end
                default: ;
            endcase
            done <= (state_n == DONE);
            busy <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_des_core.sv
// tb/tb_des_core.sv - Self-checking bench for des_core against a key-table DES reference model.
module tb_des_core;
    parameter int RPC = 1;
    localparam int N = 16 / RPC;

    logic        clk = 1'b0;
    logic        reset, enable, mode, ack;
    logic [63:0] message, DESkey, result;
    logic        done, busy;
`ifdef DES_CBC_EN
    logic [63:0] cbc_iv;
    logic        cbc_restart;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    des_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .message(message), .DESkey(DESkey),
`ifdef DES_CBC_EN
        .iv(cbc_iv), .chain_restart(cbc_restart),
`endif
        .ack(ack), .result(result), .done(done), .busy(busy));

    int ip_t[$]  = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                     62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                     57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                     61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    int p_t[$]   = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int pc1_t[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int pc2_t[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                     26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                     51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int fp_t[$];
    int e_t[$];
    int sb[8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

    // Values are right-aligned in 64 bits; table entries are 1-based from the MSB of a win-bit word.
    function automatic logic [63:0] perm(input logic [63:0] x, input int win, input int tab[$]);
        logic [63:0] r = '0;
        int wout = tab.size();
        for (int p = 0; p < wout; p++) r[6'(wout - 1 - p)] = x[6'(win - tab[p])];
        return r;
    endfunction

    function automatic logic [31:0] sbox_ref(input logic [47:0] x);
        logic [31:0] o = '0;
        int six, row, col;
        for (int b = 0; b < 8; b++) begin
            six = int'((x >> (42 - 6 * b)) & 48'h3f);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            o = (o << 4) | 32'(sb[b][row][col]);
        end
        return o;
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        logic [63:0] cd, x;
        logic [27:0] c, d;
        logic [47:0] ks [1:16];
        logic [47:0] k;
        logic [31:0] l, r, t;
        int s;
        cd = perm(key, 64, pc1_t);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 1; i <= 16; i++) begin
            s = (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
            c = (c << s) | (c >> (28 - s));
            d = (d << s) | (d >> (28 - s));
            ks[i] = 48'(perm({8'h0, c, d}, 56, pc2_t));
        end
        x = perm(blk, 64, ip_t);
        l = x[63:32];
        r = x[31:0];
        for (int n = 1; n <= 16; n++) begin
            k = dec ? ks[17 - n] : ks[n];
            t = r;
            r = l ^ 32'(perm({32'h0, sbox_ref(48'(perm({32'h0, r}, 32, e_t)) ^ k)}, 32, p_t));
            l = t;
        end
        return perm({r, l}, 64, fp_t);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic m, input logic [63:0] msg, input logic [63:0] key,
                             output logic [63:0] res, output int lat);
        mode = m; message = msg; DESkey = key; enable = 1'b1;
        tick();
        enable = 1'b0;
        lat = 0;
        while (!done && lat < 64) begin
            tick();
            lat++;
        end
        res = result;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic xact(input string tag, input logic m, input logic [63:0] msg,
                        input logic [63:0] key, input logic [63:0] exp);
        logic [63:0] res;
        int lat;
        run_block(m, msg, key, res, lat);
        chk(tag, res, exp);
        chk({tag, "_lat"}, 64'(lat), 64'(N + 1));
        do_ack();
    endtask

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;

    logic [63:0] rk, rm, mb, exp_a, exp_b, res;
    logic        rmode;
    int          lat;

    initial begin
        for (int i = 0; i < 64; i++) fp_t.push_back(0);
        for (int i = 0; i < 64; i++) fp_t[ip_t[i] - 1] = i + 1;
        for (int p = 0; p < 48; p++) e_t.push_back(((4 * (p / 6) + (p % 6) - 1 + 32) % 32) + 1);

        reset = 1'b0; enable = 1'b0; ack = 1'b0; mode = 1'b0; message = '0; DESkey = '0;
`ifdef DES_CBC_EN
        cbc_iv = '0; cbc_restart = 1'b1;
`endif
        repeat (3) tick();
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        reset = 1'b1;
        tick();

        xact("ecb_enc", 1'b0, P1, K1, C1);
        xact("ecb_dec", 1'b1, C1, K1, P1);
        xact("weak_dec", 1'b1, 64'h95F8A5E5DD31D900, 64'h0101010101010101, 64'h8000000000000000);

        for (int i = 0; i < 8; i++) begin
            rk = {$urandom, $urandom};
            rm = {$urandom, $urandom};
            rmode = 1'($urandom_range(0, 1));
            xact("rand", rmode, rm, rk, des_ref(rk, rm, rmode));
        end

        // enable held across a ROUND edge with a different block presented
        exp_a = des_ref(K1, P1, 1'b0);
        mode = 1'b0; message = P1; DESkey = K1; enable = 1'b1;
        tick();
        mode = 1'b1; message = ~P1;
        tick();
        enable = 1'b0;
        lat = 1;
        while (!done && lat < 64) begin
            tick();
            lat++;
        end
        chk("ign_enable", result, exp_a);
        chk("ign_enable_lat", 64'(lat), 64'(N + 1));

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_done", 64'(done), 64'd1);
            chk("hold_result", result, exp_a);
        end

        mb = {$urandom, $urandom};
        exp_b = des_ref(K1, mb, 1'b0);
        mode = 1'b0; message = mb; enable = 1'b1; ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_en_busy", 64'(busy), 64'd0);
        chk("ack_en_done", 64'(done), 64'd0);
        tick();
        enable = 1'b0;
        chk("accept_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 64) begin
            tick();
            lat++;
        end
        chk("after_ack_res", result, exp_b);
        chk("after_ack_lat", 64'(lat), 64'(N + 1));
        do_ack();
        tick();
        chk("no_queue_busy", 64'(busy), 64'd0);

        // reset with half the rounds applied
        mode = 1'b1; message = mb; DESkey = K1; enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (N / 2) tick();
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_result", result, 64'd0);
        xact("post_rst", 1'b1, C1, K1, P1);

`ifdef DES_CBC_EN
        cbc_iv = '0; cbc_restart = 1'b1;
        run_block(1'b0, P1, K1, res, lat);
        chk("cbc_enc1", res, C1);
        do_ack();
        cbc_restart = 1'b0;
        exp_b = des_ref(K1, P1 ^ C1, 1'b0);
        run_block(1'b0, P1, K1, res, lat);
        chk("cbc_enc2", res, exp_b);
        chk("cbc_enc2_lat", 64'(lat), 64'(N + 1));
        do_ack();
        cbc_restart = 1'b1;
        run_block(1'b1, C1, K1, res, lat);
        chk("cbc_dec1", res, P1);
        do_ack();
        cbc_restart = 1'b0;
        run_block(1'b1, exp_b, K1, res, lat);
        chk("cbc_dec2", res, P1);
        do_ack();
        cbc_restart = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
